// File: rtl/veryrisc_mem_responder.sv
// VeryRISC memory-side bus responder.
// Holds a 2^ADDR_W x DATA_W word store and answers rd / wr+data_e strobes
// one access at a time, after WAIT_STATES wait cycles, raising ready on
// completion. A preload port writes the store while the bus is idle.
module veryrisc_mem_responder #(
   parameter int ADDR_W      = 5,
   parameter int DATA_W      = 8,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic              rd,
   input  logic              wr,
   input  logic              data_e,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              ready,
   output logic              busy,
   output logic              err,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   localparam int         DEPTH   = 1 << ADDR_W;
   localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

   logic [DATA_W-1:0] mem [DEPTH];

   logic [1:0]        state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              op_q;

   logic rd_req;
   logic wr_req;
   logic viol;
   logic op_strobe;
   logic finish;
   logic commit_wr;
   logic prog_wr;

   // Request decode: legal requests and protocol violations are only looked at in IDLE.
   always_comb begin
      rd_req    = (state == S_IDLE) && rd && !wr;
      wr_req    = (state == S_IDLE) && wr && !rd && data_e;
      viol      = (state == S_IDLE) && ((rd && wr) || (wr && !data_e));
      op_strobe = (op_q == OP_WRITE) ? wr : rd;
      finish    = (state == S_WAIT) && op_strobe && (cnt == 4'd0);
      commit_wr = finish && (op_q == OP_WRITE);
      prog_wr   = (state == S_IDLE) && prog_we;
   end

   assign busy = (state != S_IDLE);

   // Capture address, write data and operation when a legal request is accepted.
   always_ff @(posedge clk) begin
      if (rd_req || wr_req) begin
         addr_q <= addr;
         data_q <= data_in;
         op_q   <= wr_req ? OP_WRITE : OP_READ;
      end
   end

   // Word store: bus write commits on DONE entry; preload only while idle (never both at once).
   always_ff @(posedge clk) begin
      if (commit_wr) begin
         mem[addr_q] <= data_q;
      end else if (prog_wr) begin
         mem[prog_addr] <= prog_data;
      end
   end

   // Access FSM: IDLE -> WAIT (count down) -> DONE (hold ready while strobe stays high).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= 4'd0;
         ready    <= 1'b0;
         err      <= 1'b0;
         data_out <= '0;
      end else begin
         err <= 1'b0;
         case (state)
            S_IDLE: begin
               ready <= 1'b0;
               // A persisting violation pulses err on alternate cycles.
               err   <= viol && !err;
               if (rd_req || wr_req) begin
                  state <= S_WAIT;
                  cnt   <= WS_LOAD;
               end
            end
            S_WAIT: begin
               if (!op_strobe) begin
                  // Strobe dropped early: abandon the access, nothing committed.
                  state <= S_IDLE;
                  cnt   <= 4'd0;
               end else if (cnt == 4'd0) begin
                  state <= S_DONE;
                  ready <= 1'b1;
                  if (op_q == OP_READ) begin
                     data_out <= mem[addr_q];
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_DONE: begin
               if (!op_strobe) begin
                  state <= S_IDLE;
                  ready <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
               ready <= 1'b0;
               cnt   <= 4'd0;
            end
         endcase
      end
   end

endmodule
